multichannel_handshake_synchronizer: RTL and testbench

//  Multi-channel 4-phase req/ack receiver for asynchronous producers. Each channel brings its req

---
 rtl/multichannel_handshake_synchronizer.sv | 122 ++++++++++++
 tb/tb_multichannel_handshake_synchronizer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_handshake_synchronizer.sv
// Per-channel 4-phase req/ack receiver: req synchronized into clk, data captured on req, delivered by valid/ready.
// Define REQ_GLITCH_FILTER_EN to add a FILTER_LEN-cycle stability filter between the synchronized req and the FSM.
module multichannel_handshake_synchronizer #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int STAGES     = 3,
  parameter int FILTER_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       async_req,
  input  logic [CHANNELS*WIDTH-1:0] async_data,
  output logic [CHANNELS-1:0]       async_ack,
  output logic [CHANNELS-1:0]       sync_valid,
  output logic [CHANNELS*WIDTH-1:0] sync_data,
  input  logic [CHANNELS-1:0]       sync_ready,
  output logic [CHANNELS-1:0]       proto_err,
  output logic [2*CHANNELS-1:0]     state_dbg   // 2 bits per channel: 0 idle, 1 valid, 2 ack
);

  if (STAGES < 2) begin : g_bad_stages
    $error("STAGES must be at least 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("FILTER_LEN must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_VALID = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  // Downstream handshake: a word transfers on a posedge where sync_valid and sync_ready are both 1;
  // sync_valid never drops and sync_data never changes while waiting for sync_ready.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [STAGES-1:0] chain_q;
    logic              req_s;
    logic              req_f;
    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  data_q;
    logic              valid_q;
    logic              ack_q;
    logic              err_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        chain_q <= '0;
      end else begin
        chain_q <= {chain_q[STAGES-2:0], async_req[c]};
      end
    end

    assign req_s = chain_q[STAGES-1];

`ifdef REQ_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [CW-1:0] cnt_q;
    logic          filt_q;

    // The filtered req follows req_s only after FILTER_LEN consecutive disagreeing cycles.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        filt_q <= 1'b0;
      end else if (req_s != filt_q) begin
        if (cnt_q == CW'(FILTER_LEN - 1)) begin
          filt_q <= req_s;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end

    assign req_f = filt_q;
`else
    assign req_f = req_s;
`endif

    always_comb begin
      state_d = state_q;
      case (state_q)
        S_IDLE:  if (req_f)            state_d = S_VALID;
        S_VALID: if (sync_ready[c])    state_d = S_ACK;
        S_ACK:   if (!req_f)           state_d = S_IDLE;
        default:                       state_d = S_IDLE;
      endcase
    end

    // ack and valid are registered so async_ack is glitch-free toward the producer.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= S_IDLE;
        data_q  <= '0;
        valid_q <= 1'b0;
        ack_q   <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        valid_q <= (state_d == S_VALID);
        ack_q   <= (state_d == S_ACK);
        if (state_q == S_IDLE && req_f) begin
          data_q <= async_data[c*WIDTH +: WIDTH];
        end
        if (state_q == S_VALID && !req_f) begin
          err_q <= 1'b1;
        end
      end
    end

    assign async_ack[c]               = ack_q;
    assign sync_valid[c]              = valid_q;
    assign sync_data[c*WIDTH +: WIDTH] = data_q;
    assign proto_err[c]               = err_q;
    assign state_dbg[2*c +: 2]        = state_q;
  end

endmodule

// File: tb/tb_multichannel_handshake_synchronizer.sv
// Bench for multichannel_handshake_synchronizer: directed scenarios plus random 4-phase producers
// checked against a transfer-level reference model and a per-channel expected-word scoreboard.
module tb_multichannel_handshake_synchronizer;
  localparam int W  = 8;
  localparam int CH = 4;
  localparam int ST = 3;
  localparam int FL = 4;
`ifdef REQ_GLITCH_FILTER_EN
  localparam int FEXTRA = FL;
`else
  localparam int FEXTRA = 0;
`endif
  localparam int LAT = ST + 1 + FEXTRA;

  logic            clk;
  logic            rst;
  logic [CH-1:0]   async_req;
  logic [CH*W-1:0] async_data;
  logic [CH-1:0]   async_ack;
  logic [CH-1:0]   sync_valid;
  logic [CH*W-1:0] sync_data;
  logic [CH-1:0]   sync_ready;
  logic [CH-1:0]   proto_err;
  logic [2*CH-1:0] state_dbg;

  multichannel_handshake_synchronizer #(
    .WIDTH(W), .CHANNELS(CH), .STAGES(ST), .FILTER_LEN(FL)
  ) dut (
    .clk(clk), .rst(rst), .async_req(async_req), .async_data(async_data),
    .async_ack(async_ack), .sync_valid(sync_valid), .sync_data(sync_data),
    .sync_ready(sync_ready), .proto_err(proto_err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // reference model: req delay line, optional filter, and transfer-level flags per channel
  bit           m_pipe[CH][$];
  bit           m_filt[CH];
  int           m_run[CH];
  bit           m_hold[CH];
  bit           m_ack[CH];
  bit           m_err[CH];
  logic [W-1:0] m_data[CH];

  logic [W-1:0] exp_q[CH][$];

  // Advance one clock: score an acceptance and step the model with the inputs the next posedge samples.
  task automatic tick();
    logic [W-1:0] e;
    bit r;
    bit eff;
    for (int c = 0; c < CH; c++) begin
      if (!rst && sync_valid[c] === 1'b1 && sync_ready[c]) begin
        total++;
        if (exp_q[c].size() == 0) begin
          bad++;
          $display("FAIL sb_ch%0d got=%0h exp=none (unexpected accept)", c, sync_data[c*W +: W]);
        end else begin
          e = exp_q[c].pop_front();
          if (sync_data[c*W +: W] !== e) begin
            bad++;
            $display("FAIL sb_ch%0d got=%0h exp=%0h", c, sync_data[c*W +: W], e);
          end
        end
      end
      if (rst) begin
        m_pipe[c].delete();
        for (int k = 0; k < ST; k++) m_pipe[c].push_back(1'b0);
        m_filt[c] = 1'b0;
        m_run[c]  = 0;
        m_hold[c] = 1'b0;
        m_ack[c]  = 1'b0;
        m_err[c]  = 1'b0;
        m_data[c] = '0;
      end else begin
        r = m_pipe[c].pop_front();
        m_pipe[c].push_back(async_req[c]);
`ifdef REQ_GLITCH_FILTER_EN
        eff = m_filt[c];
        if (r != m_filt[c]) begin
          m_run[c]++;
          if (m_run[c] == FL) begin
            m_filt[c] = r;
            m_run[c]  = 0;
          end
        end else begin
          m_run[c] = 0;
        end
`else
        eff = r;
`endif
        if (m_hold[c]) begin
          if (!eff) m_err[c] = 1'b1;
          if (sync_ready[c]) begin
            m_hold[c] = 1'b0;
            m_ack[c]  = 1'b1;
          end
        end else if (m_ack[c]) begin
          if (!eff) m_ack[c] = 1'b0;
        end else if (eff) begin
          m_hold[c] = 1'b1;
          m_data[c] = async_data[c*W +: W];
        end
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; async_req = '0; async_data = '0; sync_ready = '0;
    tick();
    tick();
    total++; if (async_ack !== '0)  begin bad++; $display("FAIL rst_ack got=%0h exp=0", async_ack); end
    total++; if (sync_valid !== '0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", sync_valid); end
    total++; if (sync_data !== '0)  begin bad++; $display("FAIL rst_data got=%0h exp=0", sync_data); end
    total++; if (proto_err !== '0)  begin bad++; $display("FAIL rst_err got=%0h exp=0", proto_err); end
    total++; if (state_dbg !== '0)  begin bad++; $display("FAIL rst_state got=%0h exp=0", state_dbg); end
    rst = 1'b0;
    for (int c = 0; c < CH; c++) exp_q[c].delete();
  endtask

  task automatic test_single();
    int cnt;
    sync_ready = 4'b0001;
    async_data[0 +: W] = 8'hA5;
    async_req[0] = 1'b1;
    exp_q[0].push_back(8'hA5);
    cnt = 0;
    do begin tick(); cnt++; end while (sync_valid[0] !== 1'b1 && cnt < 60);
    total++; if (cnt != LAT) begin bad++; $display("FAIL single_lat got=%0d exp=%0d", cnt, LAT); end
    total++; if (sync_valid !== 4'b0001) begin bad++; $display("FAIL single_valid got=%0h exp=1", sync_valid); end
    total++; if (sync_data[0 +: W] !== 8'hA5) begin bad++; $display("FAIL single_data got=%0h exp=a5", sync_data[0 +: W]); end
    tick();
    total++; if (sync_valid !== 4'b0000) begin bad++; $display("FAIL single_valid_drop got=%0h exp=0", sync_valid); end
    total++; if (async_ack !== 4'b0001) begin bad++; $display("FAIL single_ack_rise got=%0h exp=1", async_ack); end
    async_req[0] = 1'b0;
    cnt = 0;
    do begin tick(); cnt++; end while (async_ack[0] !== 1'b0 && cnt < 60);
    total++; if (cnt != LAT) begin bad++; $display("FAIL single_ack_fall got=%0d exp=%0d", cnt, LAT); end
    sync_ready = '0;
  endtask

  task automatic test_backpressure();
    int cnt;
    sync_ready = '0;
    async_data[2*W +: W] = 8'h3C;
    async_req[2] = 1'b1;
    exp_q[2].push_back(8'h3C);
    cnt = 0;
    do begin tick(); cnt++; end while (sync_valid[2] !== 1'b1 && cnt < 60);
    total++; if (cnt != LAT) begin bad++; $display("FAIL bp_lat got=%0d exp=%0d", cnt, LAT); end
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if (sync_valid[2] !== 1'b1) begin bad++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, sync_valid[2]); end
      total++; if (sync_data[2*W +: W] !== 8'h3C) begin bad++; $display("FAIL bp_hold_data cyc=%0d got=%0h exp=3c", i, sync_data[2*W +: W]); end
      total++; if (async_ack[2] !== 1'b0) begin bad++; $display("FAIL bp_hold_ack cyc=%0d got=%b exp=0", i, async_ack[2]); end
    end
    sync_ready[2] = 1'b1;
    tick();
    total++; if (sync_valid[2] !== 1'b0) begin bad++; $display("FAIL bp_accept_valid got=%b exp=0", sync_valid[2]); end
    total++; if (async_ack[2] !== 1'b1) begin bad++; $display("FAIL bp_accept_ack got=%b exp=1", async_ack[2]); end
    sync_ready[2] = 1'b0;
    async_req[2] = 1'b0;
    cnt = 0;
    do begin tick(); cnt++; end while (async_ack[2] !== 1'b0 && cnt < 60);
    total++; if (cnt != LAT) begin bad++; $display("FAIL bp_ack_fall got=%0d exp=%0d", cnt, LAT); end
  endtask

  task automatic test_proto_err();
    int cnt;
    logic [W-1:0] d;
    d = W'($urandom_range(0, 255));
    sync_ready = '0;
    async_data[1*W +: W] = d;
    async_req[1] = 1'b1;
    exp_q[1].push_back(d);
    cnt = 0;
    do begin tick(); cnt++; end while (sync_valid[1] !== 1'b1 && cnt < 60);
    total++; if (sync_valid[1] !== 1'b1) begin bad++; $display("FAIL pe_wait_valid got=%b exp=1", sync_valid[1]); end
    async_req[1] = 1'b0;
    repeat (ST + FEXTRA + 3) tick();
    total++; if (proto_err !== 4'b0010) begin bad++; $display("FAIL pe_flag got=%0h exp=2", proto_err); end
    total++; if (sync_valid[1] !== 1'b1) begin bad++; $display("FAIL pe_still_valid got=%b exp=1", sync_valid[1]); end
    total++; if (sync_data[1*W +: W] !== d) begin bad++; $display("FAIL pe_data got=%0h exp=%0h", sync_data[1*W +: W], d); end
    sync_ready[1] = 1'b1;
    tick();
    total++; if (sync_valid[1] !== 1'b0) begin bad++; $display("FAIL pe_accept_valid got=%b exp=0", sync_valid[1]); end
    total++; if (async_ack[1] !== 1'b1) begin bad++; $display("FAIL pe_accept_ack got=%b exp=1", async_ack[1]); end
    tick();
    total++; if (async_ack[1] !== 1'b0) begin bad++; $display("FAIL pe_ack_fall got=%b exp=0", async_ack[1]); end
    sync_ready[1] = 1'b0;
    repeat (4) tick();
    total++; if (sync_valid[1] !== 1'b0) begin bad++; $display("FAIL pe_idle got=%b exp=0", sync_valid[1]); end
    total++; if (proto_err !== 4'b0010) begin bad++; $display("FAIL pe_sticky got=%0h exp=2", proto_err); end
  endtask

  task automatic test_all_channels();
    int cnt;
    sync_ready = '0;
    async_data = {8'h44, 8'h33, 8'h22, 8'h11};
    async_req = 4'hF;
    exp_q[0].push_back(8'h11);
    exp_q[1].push_back(8'h22);
    exp_q[2].push_back(8'h33);
    exp_q[3].push_back(8'h44);
    cnt = 0;
    do begin tick(); cnt++; end while (sync_valid === 4'h0 && cnt < 60);
    total++; if (sync_valid !== 4'hF) begin bad++; $display("FAIL all_valid got=%0h exp=f", sync_valid); end
    total++; if (cnt != LAT) begin bad++; $display("FAIL all_lat got=%0d exp=%0d", cnt, LAT); end
    total++; if (sync_data !== 32'h44332211) begin bad++; $display("FAIL all_data got=%0h exp=44332211", sync_data); end
    sync_ready = 4'hF;
    tick();
    total++; if (sync_valid !== 4'h0) begin bad++; $display("FAIL all_accept_valid got=%0h exp=0", sync_valid); end
    total++; if (async_ack !== 4'hF) begin bad++; $display("FAIL all_ack got=%0h exp=f", async_ack); end
    sync_ready = '0;
    async_req = '0;
    cnt = 0;
    do begin tick(); cnt++; end while (async_ack !== 4'h0 && cnt < 60);
    total++; if (async_ack !== 4'h0) begin bad++; $display("FAIL all_ack_fall got=%0h exp=0", async_ack); end
    total++; if (proto_err !== 4'b0010) begin bad++; $display("FAIL all_err got=%0h exp=2", proto_err); end
  endtask

`ifdef REQ_GLITCH_FILTER_EN
  task automatic test_glitch();
    sync_ready = 4'b1000;
    async_data[3*W +: W] = 8'h77;
    async_req[3] = 1'b1;
    tick();
    tick();
    async_req[3] = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      total++; if (sync_valid[3] !== 1'b0) begin bad++; $display("FAIL glitch_valid cyc=%0d got=%b exp=0", i, sync_valid[3]); end
    end
    total++; if (async_ack[3] !== 1'b0) begin bad++; $display("FAIL glitch_ack got=%b exp=0", async_ack[3]); end
    sync_ready = '0;
  endtask
`endif

  task automatic test_reset_mid();
    int cnt;
    sync_ready = '0;
    async_data[0 +: W] = 8'h5A;
    async_req[0] = 1'b1;
    exp_q[0].push_back(8'h5A);
    cnt = 0;
    do begin tick(); cnt++; end while (sync_valid[0] !== 1'b1 && cnt < 60);
    total++; if (sync_valid[0] !== 1'b1) begin bad++; $display("FAIL rm_wait_valid got=%b exp=1", sync_valid[0]); end
    rst = 1'b1;
    async_req[0] = 1'b0;
    tick();
    total++; if (sync_valid !== '0) begin bad++; $display("FAIL rm_valid got=%0h exp=0", sync_valid); end
    total++; if (async_ack !== '0)  begin bad++; $display("FAIL rm_ack got=%0h exp=0", async_ack); end
    total++; if (sync_data !== '0)  begin bad++; $display("FAIL rm_data got=%0h exp=0", sync_data); end
    total++; if (proto_err !== '0)  begin bad++; $display("FAIL rm_err got=%0h exp=0", proto_err); end
    rst = 1'b0;
    for (int c = 0; c < CH; c++) exp_q[c].delete();
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (sync_valid !== '0) begin bad++; $display("FAIL rm_no_recapture cyc=%0d got=%0h exp=0", i, sync_valid); end
    end
  endtask

  task automatic test_random();
    int ph[CH];
    int gap[CH];
    bit stop;
    logic [W-1:0] d;
    logic [CH-1:0] ev, ea, ee;
    logic [CH*W-1:0] ed;
    rst = 1'b1; async_req = '0; sync_ready = '0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < CH; c++) begin
      exp_q[c].delete();
      ph[c] = 0;
      gap[c] = 0;
    end
    stop = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (n >= 450) stop = 1'b1;
      for (int c = 0; c < CH; c++) begin
        sync_ready[c] = stop ? 1'b1 : ($urandom_range(0, 3) != 0);
        case (ph[c])
          0: if (gap[c] > 0) gap[c]--;
             else if (!stop && async_ack[c] === 1'b0) begin
               d = W'($urandom_range(0, 255));
               async_data[c*W +: W] = d;
               async_req[c] = 1'b1;
               exp_q[c].push_back(d);
               ph[c] = 1;
             end
          1: if (async_ack[c] === 1'b1) begin
               async_req[c] = 1'b0;
               ph[c] = 2;
             end else if (sync_valid[c] === 1'b1 && $urandom_range(0, 15) == 0) begin
               async_req[c] = 1'b0;
               ph[c] = 3;
             end
          3: if (async_ack[c] === 1'b1) ph[c] = 2;
          default: if (async_ack[c] === 1'b0) begin
               ph[c] = 0;
               gap[c] = $urandom_range(0, 5);
             end
        endcase
      end
      tick();
      for (int c = 0; c < CH; c++) begin
        ev[c] = m_hold[c];
        ea[c] = m_ack[c];
        ee[c] = m_err[c];
        ed[c*W +: W] = m_data[c];
      end
      total++; if (sync_valid !== ev) begin bad++; $display("FAIL rnd_valid n=%0d got=%0h exp=%0h", n, sync_valid, ev); end
      total++; if (async_ack !== ea)  begin bad++; $display("FAIL rnd_ack n=%0d got=%0h exp=%0h", n, async_ack, ea); end
      total++; if (proto_err !== ee)  begin bad++; $display("FAIL rnd_err n=%0d got=%0h exp=%0h", n, proto_err, ee); end
      total++; if (sync_data !== ed)  begin bad++; $display("FAIL rnd_data n=%0d got=%0h exp=%0h", n, sync_data, ed); end
    end
    for (int c = 0; c < CH; c++) begin
      total++; if (ph[c] != 0) begin bad++; $display("FAIL rnd_drain_ch%0d got=phase%0d exp=phase0", c, ph[c]); end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    async_req = '0;
    async_data = '0;
    sync_ready = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_proto_err();
    test_all_channels();
`ifdef REQ_GLITCH_FILTER_EN
    test_glitch();
`endif
    test_reset_mid();
    test_random();
    for (int c = 0; c < CH; c++) begin
      total++;
      if (exp_q[c].size() != 0) begin
        bad++;
        $display("FAIL sb_leftover_ch%0d got=%0d exp=0", c, exp_q[c].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
